sprite_line_sched: RTL and testbench
====================================

// Module: sprite_line_sched
// PURPOSE
//  Per-scanline scheduler sharing SLOTS hardware sprite engines among SPR_CNT logical sprites.
//  Host writes sprite positions into a shadow table; the table commits to an active table at frame start.
//  Each line, it scans the active table and picks up to SLOTS sprites intersecting the next line.
//  Outputs drive sprx/spry of the sprite engines; sits between the VDU register interface and sprite instances.
// PARAMETERS
//  CORDW      16   signed coordinate width
//  SPR_CNT    8    logical sprites in table (power of 2, >=2)
//  SLOTS      2    hardware sprite engines fed (1..SPR_CNT)
//  SPR_HEIGHT 8    bitmap height, pixels
//  SPR_SCALE  3    scale exponent; on-screen height = SPR_HEIGHT<<SPR_SCALE
//  V_RES      272  active lines per frame
// PORTS
//  clk_pix    in   1               pixel clock; single clock domain
//  rst_pix_n  in   1               asynchronous, active-low reset
//  frame      in   1               1-cycle pulse, start of frame
//  line       in   1               1-cycle pulse, start of line
//  sy         in   CORDW           current line (signed), valid on line pulse
//  reg_we     in   1               shadow table write strobe
//  reg_idx    in   $clog2(SPR_CNT) entry written
//  reg_en     in   1               entry enable
//  reg_x      in   CORDW           entry x (signed)
//  reg_y      in   CORDW           entry y (signed)
//  slot_valid out  SLOTS           slot s holds a sprite for current line
//  slot_idx   out  SLOTS*$clog2(SPR_CNT)  logical index per slot
//  slot_x     out  SLOTS*CORDW     sprx per slot
//  slot_y     out  SLOTS*CORDW     spry per slot
//  sched_done out  1               1-cycle pulse, scan finished
//  overflow   out  1               1-cycle pulse with sched_done: >SLOTS hits, extras dropped
// BEHAVIOUR
//  Reset: all outputs 0; shadow and active tables cleared (en=0, x=y=0); FSM IDLE.
//  Table: reg_we writes shadow[reg_idx] on the clock edge. On frame, active<=shadow (pre-write
//   values if reg_we coincides with frame; the write lands in shadow only).
//  Target line T = sy+1, or 0 when sy>=V_RES-1; captured on line pulse.
//  FSM IDLE -line-> SCAN; SCAN examines one entry per cycle, index 0..SPR_CNT-1; after last
//   entry -> DONE (1 cycle: sched_done, overflow) -> IDLE. Scan = SPR_CNT cycles + 1.
//  Hit: en && y <= T < y+(SPR_HEIGHT<<SPR_SCALE); compare in CORDW+1 bits signed, no wrap.
//  Allocation: hits fill pending slots 0..SLOTS-1 in ascending index (lower index = priority).
//   Further hits set overflow flag; not stored.
//  Promotion: on next line pulse, pending -> slot_* outputs (visible cycle after pulse);
//   pending cleared and new scan starts same cycle. Latency: line L data valid one cycle
//   after the line pulse with sy==L; stable for whole line.
//  frame+line same cycle: commit first; the scan started that cycle uses the new active table.
//  line during SCAN/DONE (incomplete scan): outputs promote as all-invalid (slot_valid=0),
//   partial pending discarded, scan restarts for the new T; no sched_done for aborted scan.
//  Writes during SCAN affect shadow only; active table is constant between frame pulses.
//  Reset asserted mid-scan: immediate return to reset state; tables lost.
// STRUCTURE
//  Package vdu_pkg: sched_state_t enum {IDLE,SCAN,DONE}; spr_entry_t struct {en,x,y};
//   function spr_line_h(SPR_HEIGHT,SPR_SCALE).
//  Sub-module sprite_table: shadow+active register arrays, write port, commit, async read by index.
//  Top: FSM, scan counter, hit compare, slot allocator, pending/output registers.
// TESTING
//  Reset then line pulses with sy=0..3 -> slot_valid=0, sched_done each line, overflow=0.
//  Write idx2 {en,x=32,y=16}; frame; line sy=15 then sy=16 -> after 2nd pulse slot_valid[0]=1,
//   slot_idx=2, x=32, y=16; held through y=79; sy=79 scan yields none -> valid=0 on line 80.
//  Enable idx0,1,5 at y=10 (SLOTS=2); line sy=9 -> overflow pulse; next line slots hold idx0,idx1.
//  Write on same cycle as frame -> active keeps old value this frame; new value after next frame.
//  Line pulse 3 cycles into SCAN -> no sched_done; next-line outputs all invalid; rescan for new T.
//  sy=V_RES-1 with sprite y=0 -> T wraps to 0; sprite scheduled for line 0; rst_pix_n low mid-scan -> all outputs 0.

Source files
------------

// File: rtl/vdu_pkg.sv
// Shared types for the VDU sprite line scheduler.
// Scheduler FSM states, table entry layout and on-screen sprite height.
package vdu_pkg;

    localparam int SPR_CORDW = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic                        en;
        logic signed [SPR_CORDW-1:0] x;
        logic signed [SPR_CORDW-1:0] y;
    } spr_entry_t;

    function automatic int spr_line_h(input int h, input int scale);
        return h << scale;
    endfunction

endpackage

// File: rtl/sprite_table.sv
// Shadow/active sprite position tables; shadow written by host,
// copied into active on frame commit, active read asynchronously.
module sprite_table
    import vdu_pkg::*;
#(
    parameter int SPR_CNT = 8,
    parameter int IW      = $clog2(SPR_CNT)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        we_i,
    input  logic [IW-1:0]               widx_i,
    input  logic                        wen_i,
    input  logic signed [SPR_CORDW-1:0] wx_i,
    input  logic signed [SPR_CORDW-1:0] wy_i,
    input  logic                        commit_i,
    input  logic [IW-1:0]               ridx_i,
    output spr_entry_t                  rd_o
);

    spr_entry_t shadow_q [SPR_CNT];
    spr_entry_t active_q [SPR_CNT];

    // Commit copies pre-write shadow; a coincident write lands in shadow only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SPR_CNT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (commit_i) active_q <= shadow_q;
            if (we_i) shadow_q[widx_i] <= '{en: wen_i, x: wx_i, y: wy_i};
        end
    end

    assign rd_o = active_q[ridx_i];

endmodule

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans the active table for the next line
// and assigns up to SLOTS intersecting sprites to hardware sprite engines.
module sprite_line_sched
    import vdu_pkg::*;
#(
    parameter int CORDW      = SPR_CORDW,
    parameter int SPR_CNT    = 8,
    parameter int SLOTS      = 2,
    parameter int SPR_HEIGHT = 8,
    parameter int SPR_SCALE  = 3,
    parameter int V_RES      = 272
) (
    input  logic                             clk_pix,
    input  logic                             rst_pix_n,
    input  logic                             frame,
    input  logic                             line,
    input  logic signed [CORDW-1:0]          sy,
    input  logic                             reg_we,
    input  logic [$clog2(SPR_CNT)-1:0]       reg_idx,
    input  logic                             reg_en,
    input  logic signed [CORDW-1:0]          reg_x,
    input  logic signed [CORDW-1:0]          reg_y,
    output logic [SLOTS-1:0]                 slot_valid,
    output logic [SLOTS*$clog2(SPR_CNT)-1:0] slot_idx,
    output logic [SLOTS*CORDW-1:0]           slot_x,
    output logic [SLOTS*CORDW-1:0]           slot_y,
    output logic                             sched_done,
    output logic                             overflow
);

    localparam int IW = $clog2(SPR_CNT);
    localparam int FW = $clog2(SLOTS + 1);
    localparam int H  = spr_line_h(SPR_HEIGHT, SPR_SCALE);
    localparam logic signed [CORDW-1:0] LAST_Y = CORDW'(V_RES - 1);

    sched_state_t state_q, state_d;

    logic [IW-1:0]           idx_q;
    logic signed [CORDW-1:0] t_q, t_d;
    logic [FW-1:0]           fill_q;
    logic                    ovf_q;
    logic [IW-1:0]           pidx_q [SLOTS];
    logic signed [CORDW-1:0] px_q   [SLOTS];
    logic signed [CORDW-1:0] py_q   [SLOTS];

    logic [SLOTS-1:0]       vld_q;
    logic [SLOTS*IW-1:0]    oidx_q;
    logic [SLOTS*CORDW-1:0] ox_q, oy_q;

    spr_entry_t            rd;
    logic signed [CORDW:0] ye, te, yend;
    logic                  hit, last;

    sprite_table #(.SPR_CNT(SPR_CNT)) u_table (
        .clk_i   (clk_pix),
        .rst_ni  (rst_pix_n),
        .we_i    (reg_we),
        .widx_i  (reg_idx),
        .wen_i   (reg_en),
        .wx_i    (reg_x),
        .wy_i    (reg_y),
        .commit_i(frame),
        .ridx_i  (idx_q),
        .rd_o    (rd)
    );

    always_comb begin
        t_d = sy + CORDW'(1);
        if (sy >= LAST_Y) t_d = '0;
    end

    // One extra bit so y+height cannot wrap near the coordinate limit.
    always_comb begin
        ye   = {rd.y[CORDW-1], rd.y};
        te   = {t_q[CORDW-1], t_q};
        yend = ye + (CORDW+1)'(H);
        hit  = rd.en && (ye <= te) && (te < yend);
        last = (idx_q == IW'(SPR_CNT - 1));
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (line) begin
            state_d = SCAN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                SCAN:    if (last) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sched_done = (state_q == DONE);
        overflow   = (state_q == DONE) && ovf_q;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            idx_q  <= '0;
            t_q    <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= '0;
            oidx_q <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                pidx_q[s] <= '0;
                px_q[s]   <= '0;
                py_q[s]   <= '0;
            end
        end else if (line) begin
            t_q    <= t_d;
            idx_q  <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
            // Only a finished scan (back in IDLE) is promoted.
            for (int s = 0; s < SLOTS; s++) begin
                if (state_q == IDLE && FW'(s) < fill_q) begin
                    vld_q[s]                <= 1'b1;
                    oidx_q[s*IW +: IW]      <= pidx_q[s];
                    ox_q[s*CORDW +: CORDW]  <= px_q[s];
                    oy_q[s*CORDW +: CORDW]  <= py_q[s];
                end else begin
                    vld_q[s]                <= 1'b0;
                    oidx_q[s*IW +: IW]      <= '0;
                    ox_q[s*CORDW +: CORDW]  <= '0;
                    oy_q[s*CORDW +: CORDW]  <= '0;
                end
            end
        end else if (state_q == SCAN) begin
            idx_q <= idx_q + 1'b1;
            for (int s = 0; s < SLOTS; s++) begin
                if (hit && fill_q == FW'(s)) begin
                    pidx_q[s] <= idx_q;
                    px_q[s]   <= rd.x;
                    py_q[s]   <= rd.y;
                end
            end
            if (hit) begin
                if (fill_q < FW'(SLOTS)) fill_q <= fill_q + 1'b1;
                else                     ovf_q  <= 1'b1;
            end
        end
    end

    assign slot_valid = vld_q;
    assign slot_idx   = oidx_q;
    assign slot_x     = ox_q;
    assign slot_y     = oy_q;

endmodule

// File: tb/tb_sprite_line_sched.sv
// Self-checking bench for sprite_line_sched against a table-level model.
module tb_sprite_line_sched;

    localparam int CORDW   = 16;
    localparam int SPR_CNT = 8;
    localparam int SLOTS   = 2;
    localparam int IW      = 3;
    localparam int H       = 64;
    localparam int V_RES   = 272;

    logic clk_pix = 1'b0;
    logic rst_pix_n = 1'b0;
    logic frame = 1'b0, line = 1'b0, reg_we = 1'b0, reg_en = 1'b0;
    logic signed [CORDW-1:0] sy = '0, reg_x = '0, reg_y = '0;
    logic [IW-1:0] reg_idx = '0;
    logic [SLOTS-1:0] slot_valid;
    logic [SLOTS*IW-1:0] slot_idx;
    logic [SLOTS*CORDW-1:0] slot_x, slot_y;
    logic sched_done, overflow;

    sprite_line_sched dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .frame(frame), .line(line),
        .sy(sy), .reg_we(reg_we), .reg_idx(reg_idx), .reg_en(reg_en),
        .reg_x(reg_x), .reg_y(reg_y), .slot_valid(slot_valid),
        .slot_idx(slot_idx), .slot_x(slot_x), .slot_y(slot_y),
        .sched_done(sched_done), .overflow(overflow)
    );

    always #5 clk_pix = ~clk_pix;

    int checks = 0;
    int failures = 0;

    int sh_en [SPR_CNT], sh_x [SPR_CNT], sh_y [SPR_CNT];
    int ac_en [SPR_CNT], ac_x [SPR_CNT], ac_y [SPR_CNT];
    int pend_i[$], pend_x[$], pend_y[$];
    int out_i[$], out_x[$], out_y[$];
    bit pend_ovf;
    bit complete;

    function automatic void reset_model();
        for (int i = 0; i < SPR_CNT; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
            ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0;
        end
        pend_i.delete(); pend_x.delete(); pend_y.delete();
        out_i.delete(); out_x.delete(); out_y.delete();
        pend_ovf = 0;
        complete = 1;
    endfunction

    function automatic void commit();
        for (int i = 0; i < SPR_CNT; i++) begin
            ac_en[i] = sh_en[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i];
        end
    endfunction

    function automatic int target(input int s);
        return (s >= V_RES - 1) ? 0 : s + 1;
    endfunction

    function automatic void scan_model(input int t);
        int n;
        n = 0;
        pend_i.delete(); pend_x.delete(); pend_y.delete();
        for (int i = 0; i < SPR_CNT; i++) begin
            if (ac_en[i] != 0 && ac_y[i] <= t && t < ac_y[i] + H) begin
                if (pend_i.size() < SLOTS) begin
                    pend_i.push_back(i);
                    pend_x.push_back(ac_x[i]);
                    pend_y.push_back(ac_y[i]);
                end
                n++;
            end
        end
        pend_ovf = (n > SLOTS);
    endfunction

    function automatic bit slots_ok();
        logic [SLOTS-1:0] ev;
        bit ok;
        ev = '0;
        ok = 1;
        for (int s = 0; s < out_i.size(); s++) begin
            ev[s] = 1'b1;
            if (slot_idx[s*IW +: IW] !== IW'(out_i[s])) ok = 0;
            if (slot_x[s*CORDW +: CORDW] !== CORDW'(out_x[s])) ok = 0;
            if (slot_y[s*CORDW +: CORDW] !== CORDW'(out_y[s])) ok = 0;
        end
        if (slot_valid !== ev) ok = 0;
        return ok;
    endfunction

    task automatic write_reg(input int idx, input int en, input int x,
                             input int y, input bit fr);
        reg_we = 1'b1; reg_idx = IW'(idx); reg_en = en[0];
        reg_x = CORDW'(x); reg_y = CORDW'(y); frame = fr;
        @(posedge clk_pix);
        if (fr) commit();
        sh_en[idx] = en; sh_x[idx] = x; sh_y[idx] = y;
        #1;
        reg_we = 1'b0; frame = 1'b0;
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        @(posedge clk_pix);
        commit();
        #1;
        frame = 1'b0;
    endtask

    task automatic do_line(input int sy_v, input bit fr, input int gap);
        int done_cnt, ovf_cnt;
        bit stray, unstable;
        sy = CORDW'(sy_v); line = 1'b1; frame = fr;
        @(posedge clk_pix);
        if (fr) commit();
        if (complete) begin
            out_i = pend_i; out_x = pend_x; out_y = pend_y;
        end else begin
            out_i.delete(); out_x.delete(); out_y.delete();
        end
        scan_model(target(sy_v));
        #1;
        line = 1'b0; frame = 1'b0;
        checks++;
        if (!slots_ok()) begin
            failures++;
            $display("FAIL promote sy=%0d: valid=%b idx=%h x=%h y=%h, need %0d slots idx0=%0d",
                     sy_v, slot_valid, slot_idx, slot_x, slot_y, out_i.size(),
                     out_i.size() > 0 ? out_i[0] : -1);
        end
        done_cnt = 0; ovf_cnt = 0; stray = 0; unstable = 0;
        for (int c = 1; c < gap; c++) begin
            @(posedge clk_pix);
            #1;
            if (sched_done) done_cnt++;
            if (overflow) begin
                ovf_cnt++;
                if (!sched_done) stray = 1;
            end
            if (!slots_ok()) unstable = 1;
        end
        complete = (gap >= SPR_CNT + 2);
        checks++;
        if (done_cnt != (complete ? 1 : 0)) begin
            failures++;
            $display("FAIL sched_done sy=%0d gap=%0d: got %0d pulses, need %0d",
                     sy_v, gap, done_cnt, complete ? 1 : 0);
        end
        if (complete) begin
            checks++;
            if (ovf_cnt != (pend_ovf ? 1 : 0)) begin
                failures++;
                $display("FAIL overflow sy=%0d: got %0d pulses, need %0d",
                         sy_v, ovf_cnt, pend_ovf ? 1 : 0);
            end
        end
        checks++;
        if (stray || unstable) begin
            failures++;
            $display("FAIL line_hold sy=%0d: stray_ovf=%0d unstable=%0d, need 0 0",
                     sy_v, stray, unstable);
        end
    endtask

    task automatic test_reset();
        reset_model();
        rst_pix_n = 1'b0;
        repeat (2) @(posedge clk_pix);
        #1;
        checks++;
        if ({slot_valid, slot_idx, slot_x, slot_y, sched_done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b idx=%h x=%h y=%h done=%b ovf=%b, need all 0",
                     slot_valid, slot_idx, slot_x, slot_y, sched_done, overflow);
        end
        rst_pix_n = 1'b1;
        @(posedge clk_pix);
        #1;
        checks++;
        if ({slot_valid, sched_done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_release: valid=%b done=%b ovf=%b, need 0",
                     slot_valid, sched_done, overflow);
        end
    endtask

    task automatic test_empty_lines();
        for (int l = 0; l < 4; l++) do_line(l, 1'b0, 12);
    endtask

    task automatic test_single();
        write_reg(2, 1, 32, 16, 1'b0);
        frame_pulse();
        do_line(15, 1'b0, 12);
        do_line(16, 1'b0, 12);
        checks++;
        if (slot_valid[0] !== 1'b1 || slot_idx[IW-1:0] !== 3'd2 ||
            slot_x[CORDW-1:0] !== 16'd32 || slot_y[CORDW-1:0] !== 16'd16) begin
            failures++;
            $display("FAIL single_line16: valid=%b idx=%0d x=%0d y=%0d, need 1 2 32 16",
                     slot_valid[0], slot_idx[IW-1:0], slot_x[CORDW-1:0], slot_y[CORDW-1:0]);
        end
        for (int l = 17; l <= 80; l++) do_line(l, 1'b0, 10);
        checks++;
        if (slot_valid !== '0) begin
            failures++;
            $display("FAIL single_line80: valid=%b, need 00", slot_valid);
        end
    endtask

    task automatic test_overflow();
        write_reg(0, 1, 40, 10, 1'b0);
        write_reg(1, 1, 50, 10, 1'b0);
        write_reg(5, 1, 60, 10, 1'b0);
        frame_pulse();
        do_line(9, 1'b0, 12);
        do_line(10, 1'b0, 12);
        checks++;
        if (slot_valid !== 2'b11 || slot_idx !== {3'd1, 3'd0}) begin
            failures++;
            $display("FAIL overflow_slots: valid=%b idx=%h, need 11 08",
                     slot_valid, slot_idx);
        end
    endtask

    task automatic test_write_frame();
        write_reg(3, 1, 100, 100, 1'b1);
        do_line(99, 1'b0, 12);
        do_line(100, 1'b0, 12);
        frame_pulse();
        do_line(99, 1'b0, 12);
        do_line(100, 1'b0, 12);
        checks++;
        if (slot_valid[0] !== 1'b1 || slot_idx[IW-1:0] !== 3'd3) begin
            failures++;
            $display("FAIL write_frame_next: valid=%b idx=%0d, need 1 3",
                     slot_valid[0], slot_idx[IW-1:0]);
        end
    endtask

    task automatic test_frame_line_abort();
        write_reg(6, 1, 7, 120, 1'b0);
        do_line(119, 1'b1, 12);
        do_line(120, 1'b0, 3);
        do_line(121, 1'b0, 12);
        checks++;
        if (slot_valid !== '0) begin
            failures++;
            $display("FAIL abort_invalid: valid=%b, need 00", slot_valid);
        end
        do_line(122, 1'b0, 12);
    endtask

    task automatic test_wrap();
        write_reg(4, 1, 8, 0, 1'b0);
        frame_pulse();
        do_line(V_RES - 1, 1'b0, 12);
        do_line(0, 1'b0, 12);
        checks++;
        if (slot_valid[0] !== 1'b1 || slot_idx[IW-1:0] !== 3'd4) begin
            failures++;
            $display("FAIL wrap_line0: valid=%b idx=%0d, need 1 4",
                     slot_valid[0], slot_idx[IW-1:0]);
        end
    endtask

    task automatic test_reset_midscan();
        do_line(1, 1'b0, 4);
        rst_pix_n = 1'b0;
        #1;
        checks++;
        if ({slot_valid, slot_idx, slot_x, slot_y, sched_done, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_midscan: valid=%b idx=%h x=%h y=%h, need all 0",
                     slot_valid, slot_idx, slot_x, slot_y);
        end
        #2;
        rst_pix_n = 1'b1;
        reset_model();
        do_line(1, 1'b0, 12);
        do_line(2, 1'b0, 12);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int gap;
            if ($urandom_range(0, 1) == 1)
                write_reg($urandom_range(0, SPR_CNT - 1), $urandom_range(0, 3) != 0 ? 1 : 0,
                          $urandom_range(0, 400) - 50, $urandom_range(0, 340) - 60,
                          $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) frame_pulse();
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : $urandom_range(10, 20);
            do_line($urandom_range(0, 380) - 80, $urandom_range(0, 5) == 0, gap);
        end
    endtask

    initial begin
        test_reset();
        test_empty_lines();
        test_single();
        test_overflow();
        test_write_frame();
        test_frame_line_abort();
        test_wrap();
        test_reset_midscan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
